// File: rtl/stream_arbiter_pkg.sv
// Shared definitions for the round-robin stream arbiter: FSM state encoding.
package stream_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_ACK  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/stream_arbiter_if.sv
// Bundle of upstream request/acknowledge lines and the single downstream port.
// The arbiter uses the master view; the surrounding sources/sink use slave.
interface stream_arbiter_if #(
  parameter int Np = 4,
  parameter int Nd = 8
) ();

  logic [Np*Nd-1:0] in_data;
  logic [Np-1:0]    in_valid;
  logic [Np-1:0]    in_busy;
  logic [Np-1:0]    grant;
  logic [Nd-1:0]    out_data;
  logic             out_valid;
  logic             out_busy;

  modport master (
    input  in_data, in_valid, out_busy,
    output in_busy, grant, out_data, out_valid
  );

  modport slave (
    output in_data, in_valid, out_busy,
    input  in_busy, grant, out_data, out_valid
  );

endinterface

// File: rtl/stream_arbiter_pick.sv
// rr_pick: combinational rotating-priority picker. Returns the first set
// request bit found scanning upward from ptr, wrapping modulo Np.
module rr_pick #(
  parameter int Np = 4
) (
  input  logic [Np-1:0]         req,
  input  logic [$clog2(Np)-1:0] ptr,
  output logic                  any,
  output logic [$clog2(Np)-1:0] idx
);

  localparam int IW = $clog2(Np);

  // Scan from the farthest offset down so the nearest request to ptr wins last.
  always_comb begin
    any = 1'b0;
    idx = '0;
    for (int k = Np - 1; k >= 0; k--) begin
      int c;
      c = int'(ptr) + k;
      if (c >= Np) c = c - Np;
      if (req[IW'(c)]) begin
        any = 1'b1;
        idx = IW'(c);
      end
    end
  end

endmodule

// File: rtl/stream_arbiter.sv
// stream_arbiter: round-robin arbiter forwarding one latched word per grant
// from Np four-phase upstream sources to a single four-phase sink. Every
// transfer returns both handshakes to idle before the next grant.
module stream_arbiter
  import stream_arbiter_pkg::*;
#(
  parameter int Np = 4,
  parameter int Nd = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  stream_arbiter_if.master bus
);

  localparam int            IW      = $clog2(Np);
  localparam logic [Np-1:0] ONE_HOT = {{(Np-1){1'b0}}, 1'b1};

  state_t          r_state,     w_state_nx;
  logic [IW-1:0]   r_ptr,       w_ptr_nx;
  logic [IW-1:0]   r_g,         w_g_nx;
  logic [Np-1:0]   r_grant,     w_grant_nx;
  logic [Np-1:0]   r_in_busy,   w_in_busy_nx;
  logic            r_out_valid, w_out_valid_nx;
  logic [Nd-1:0]   r_out_data,  w_out_data_nx;

  logic            w_any;
  logic [IW-1:0]   w_idx;

  // Pointer to the requester after g, wrapping explicitly for any Np.
  function automatic logic [IW-1:0] ptr_after(input logic [IW-1:0] g);
    if (g == IW'(Np - 1)) return '0;
    else                  return g + 1'b1;
  endfunction

  rr_pick #(.Np(Np)) u_pick (
    .req (bus.in_valid),
    .ptr (r_ptr),
    .any (w_any),
    .idx (w_idx)
  );

  // Next-state and next-output decode; every output is a register, so inputs
  // only ever reach the pins through this block and the state flops.
  always_comb begin
    w_state_nx     = r_state;
    w_ptr_nx       = r_ptr;
    w_g_nx         = r_g;
    w_grant_nx     = r_grant;
    w_in_busy_nx   = r_in_busy;
    w_out_valid_nx = r_out_valid;
    w_out_data_nx  = r_out_data;
    case (r_state)
      ST_IDLE: begin
        // A sink still showing busy has not finished its previous handshake.
        if (w_any && !bus.out_busy) begin
          w_g_nx         = w_idx;
          w_out_data_nx  = bus.in_data[w_idx*Nd +: Nd];
          w_grant_nx     = ONE_HOT << w_idx;
          w_out_valid_nx = 1'b1;
          w_state_nx     = ST_SEND;
        end
      end
      ST_SEND: begin
        if (bus.out_busy) begin
          w_out_valid_nx = 1'b0;
          w_in_busy_nx   = r_grant;
          w_state_nx     = ST_ACK;
        end
      end
      ST_ACK: begin
        if (!bus.in_valid[r_g] && !bus.out_busy) begin
          w_in_busy_nx = '0;
          w_grant_nx   = '0;
          w_ptr_nx     = ptr_after(r_g);
          w_state_nx   = ST_DONE;
        end
      end
      ST_DONE: begin
        // Gives the last owner one cycle to observe in_busy low.
        w_state_nx = ST_IDLE;
      end
      default: begin
        w_state_nx = ST_IDLE;
      end
    endcase
  end

  // State, pointer and output registers; reset drops everything immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_ptr       <= '0;
      r_g         <= '0;
      r_grant     <= '0;
      r_in_busy   <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else begin
      r_state     <= w_state_nx;
      r_ptr       <= w_ptr_nx;
      r_g         <= w_g_nx;
      r_grant     <= w_grant_nx;
      r_in_busy   <= w_in_busy_nx;
      r_out_valid <= w_out_valid_nx;
      r_out_data  <= w_out_data_nx;
    end
  end

  assign bus.in_busy   = r_in_busy;
  assign bus.grant     = r_grant;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;

endmodule
